// File: rtl/rr_note_player.sv
// rr_note_player: plays one square-wave note per accepted request, then a fixed silent gap.
module rr_note_player #(
    parameter int TICK_DIV  = 1000,
    parameter int GAP_TICKS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        note_valid,
    input  logic [15:0] note_period,
    input  logic [7:0]  note_len,
    input  logic        stop,
    output logic        note_ready,
    output logic        audio,
    output logic        busy,
    output logic        done
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int RW = (GAP_TICKS > 255) ? $clog2(GAP_TICKS + 1) : 8;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tick_cnt, tick_n;
    logic [RW-1:0]   rem, rem_n;
    logic [15:0]     tone_cnt, tone_n, period_q, period_n;
    logic            audio_n, done_n;
    logic            accept, tick_wrap, last_tick, tone_wrap;

    assign note_ready = (state == IDLE);
    assign busy       = (state == PLAY) | (state == GAP);

    // rem counts note ticks in PLAY and gap ticks in GAP; its last tick ends the phase
    always_comb begin
        accept    = note_ready & note_valid & ~stop;
        tick_wrap = (state != IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
        last_tick = tick_wrap && (rem == RW'(1));
        tone_wrap = (tone_cnt == period_q - 16'd1);
        state_n   = state;
        done_n    = 1'b0;
        tick_n    = (tick_wrap || state == IDLE) ? '0 : tick_cnt + 1'b1;
        rem_n     = tick_wrap ? rem - 1'b1 : rem;
        period_n  = period_q;
        tone_n    = '0;
        audio_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    period_n = note_period;
                    if (note_len != 8'd0) begin
                        state_n = PLAY;
                        rem_n   = RW'(note_len);
                    end else if (GAP_TICKS != 0) begin
                        state_n = GAP;
                        rem_n   = RW'(GAP_TICKS);
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (last_tick) begin
                    state_n = (GAP_TICKS != 0) ? GAP : IDLE;
                    rem_n   = RW'(GAP_TICKS);
                    done_n  = (GAP_TICKS == 0);
                end else if (period_q != 16'd0) begin
                    tone_n  = tone_wrap ? '0 : tone_cnt + 1'b1;
                    audio_n = audio ^ tone_wrap;
                end
            end
            GAP: begin
                if (last_tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (stop) begin
            state_n = IDLE;
            done_n  = 1'b0;
            tick_n  = '0;
            rem_n   = '0;
            tone_n  = '0;
            audio_n = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            rem      <= '0;
            tone_cnt <= '0;
            period_q <= '0;
            audio    <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick_cnt <= tick_n;
            rem      <= rem_n;
            tone_cnt <= tone_n;
            period_q <= period_n;
            audio    <= audio_n;
            done     <= done_n;
        end
    end
endmodule

// File: doc/rr_note_player.md
RR_NOTE_PLAYER -- requirements
Module: rr_note_player

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, clocks per duration tick (valid range >= 2).
REQ-002 SHALL have parameter GAP_TICKS, default 2, silent ticks inserted after each note (valid range >= 0).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port note_valid  input  1  upstream note request present.
REQ-006 SHALL have port note_period  input  16  audio half-period in clocks; 0 = rest.
REQ-007 SHALL have port note_len  input  8  note duration in ticks.
REQ-008 SHALL have port stop  input  1  synchronous abort of the current note/gap.
REQ-009 SHALL have port note_ready  output  1  block can accept a note this cycle.
REQ-010 SHALL have port audio  output  1  square-wave tone output.
REQ-011 SHALL have port busy  output  1  high while in PLAY or GAP.
REQ-012 SHALL have port done  output  1  one-cycle pulse on normal note completion.

Function
REQ-013 SHALL implement the states IDLE, PLAY and GAP.
REQ-014 SHALL assert note_ready only in IDLE, combinationally from state, independent of note_valid.
REQ-015 SHALL accept a note on a rising edge where note_valid & note_ready & !stop, latching note_period and note_len.
REQ-016 On acceptance with note_len != 0: next state PLAY; tone counter = 0; tick counter = 0; remaining = note_len; audio = 0.
REQ-017 On acceptance with note_len == 0: go to GAP (or straight to IDLE with done if GAP_TICKS == 0); no tone is produced.
REQ-018 In PLAY with period P != 0: tone counter increments every clock; on reaching P-1 it SHALL clear and audio SHALL toggle, so each audio level lasts exactly P clocks.
REQ-019 In PLAY with period 0 (rest), audio SHALL remain 0.
REQ-020 Tick counter SHALL count 0..TICK_DIV-1 in PLAY and GAP; wrapping from TICK_DIV-1 constitutes one tick.
REQ-021 Each tick in PLAY SHALL decrement remaining; the tick taking remaining from 1 to 0 SHALL move the block to GAP with audio = 0, so PLAY lasts exactly note_len*TICK_DIV clocks.
REQ-022 GAP SHALL last exactly GAP_TICKS*TICK_DIV clocks with audio = 0; if GAP_TICKS == 0, PLAY SHALL go directly to IDLE.
REQ-023 The cycle after the final PLAY or GAP clock, the state SHALL be IDLE and done SHALL be 1 for exactly that one cycle.
REQ-024 A new note SHALL be acceptable in that same done cycle (back-to-back operation).
REQ-025 stop high on a rising edge SHALL force IDLE and clear audio and all counters; done SHALL not be pulsed.
REQ-026 stop SHALL take priority over acceptance and over every state transition occurring on the same edge.
REQ-027 busy SHALL equal (state == PLAY) | (state == GAP).
REQ-028 Latched period and length SHALL be ignored-by-change: upstream input changes after acceptance SHALL not affect the note in progress.
REQ-029 All counters SHALL be sized to hold TICK_DIV-1, 65535 and 255 without overflow.

Reset
REQ-030 Reset asserted SHALL immediately force IDLE, audio = 0, done = 0, busy = 0, all counters = 0, and note_ready = 1.
REQ-031 Reset mid-note SHALL abandon the note without a done pulse; the first acceptance is possible on the first rising edge after reset deasserts.

Verification (TICK_DIV=4, GAP_TICKS=1 unless stated)
REQ-032 Accept period=3, len=2 -> audio 0 for 3 clocks, then 1 for 3, then 0 for 2 (8 PLAY clocks); then 4 GAP clocks at 0; then done for 1 cycle.
REQ-033 Accept period=0, len=1 -> audio stays 0; busy high for 8 clocks; then done for 1 cycle.
REQ-034 note_valid held high with two queued notes -> second accepted in the done cycle of the first; no idle gap beyond GAP_TICKS.
REQ-035 stop asserted at PLAY clock 5 with note_valid high -> IDLE next cycle, audio 0, no done, note not re-accepted on the stop edge.
REQ-036 Reset pulsed mid-GAP -> outputs at reset values immediately; new note period=2, len=1 plays correctly afterwards.
REQ-037 GAP_TICKS=0, len=0 -> done on the cycle after acceptance; busy never asserted.
